// File: rtl/wb8_pkg.sv
// Shared definitions for the 8-bit Wishbone initiator: FSM encoding and timeout defaults.
package wb8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } wb8_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;
    localparam int CNT_WIDTH              = 8;

endpackage

// File: rtl/wb8_initiator.sv
// Single-transaction Wishbone classic initiator: valid/ready command in, one bus cycle,
// then a held response (read data or timeout error) on a valid/ready response port.
module wb8_initiator
    import wb8_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  I_wb_clk,
    input  logic                  I_reset,
    input  logic                  I_cmd_valid,
    output logic                  O_cmd_ready,
    input  logic                  I_cmd_we,
    input  logic [ADDR_WIDTH-1:0] I_cmd_adr,
    input  logic [7:0]            I_cmd_dat,
    output logic                  O_rsp_valid,
    input  logic                  I_rsp_ready,
    output logic [7:0]            O_rsp_dat,
    output logic                  O_rsp_err,
    output logic                  O_wb_cyc,
    output logic                  O_wb_stb,
    output logic                  O_wb_we,
    output logic [ADDR_WIDTH-1:0] O_wb_adr,
    output logic [7:0]            O_wb_dat,
    input  logic                  I_wb_ack,
    input  logic [7:0]            I_wb_dat
);

    // Abort decision is taken in the BUS cycle whose counter value is TIMEOUT_CYCLES-1,
    // so STB is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    wb8_state_e            state, state_next;
    logic [CNT_WIDTH-1:0]  tmo_cnt, tmo_cnt_next;
    logic                  cmd_fire, ack_seen, tmo_hit;

    logic                  cmd_ready_next, rsp_valid_next, rsp_err_next;
    logic [7:0]            rsp_dat_next, wb_dat_next;
    logic                  wb_cyc_next, wb_stb_next, wb_we_next;
    logic [ADDR_WIDTH-1:0] wb_adr_next;

    assign cmd_fire = I_cmd_valid && O_cmd_ready;
    assign ack_seen = I_wb_ack && O_wb_stb;
    assign tmo_hit  = (tmo_cnt >= TIMEOUT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            O_cmd_ready <= 1'b0;
            O_rsp_valid <= 1'b0;
            O_rsp_dat   <= 8'h00;
            O_rsp_err   <= 1'b0;
            O_wb_cyc    <= 1'b0;
            O_wb_stb    <= 1'b0;
            O_wb_we     <= 1'b0;
            O_wb_adr    <= '0;
            O_wb_dat    <= 8'h00;
        end else begin
            state       <= state_next;
            tmo_cnt     <= tmo_cnt_next;
            O_cmd_ready <= cmd_ready_next;
            O_rsp_valid <= rsp_valid_next;
            O_rsp_dat   <= rsp_dat_next;
            O_rsp_err   <= rsp_err_next;
            O_wb_cyc    <= wb_cyc_next;
            O_wb_stb    <= wb_stb_next;
            O_wb_we     <= wb_we_next;
            O_wb_adr    <= wb_adr_next;
            O_wb_dat    <= wb_dat_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_fire)             state_next = ST_BUS;
            ST_BUS:  if (ack_seen || tmo_hit)  state_next = ST_GAP;
            ST_GAP:                            state_next = ST_RESP;
            ST_RESP: if (I_rsp_ready)          state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        tmo_cnt_next   = tmo_cnt;
        rsp_dat_next   = O_rsp_dat;
        rsp_err_next   = O_rsp_err;
        wb_cyc_next    = O_wb_cyc;
        wb_stb_next    = O_wb_stb;
        wb_we_next     = O_wb_we;
        wb_adr_next    = O_wb_adr;
        wb_dat_next    = O_wb_dat;
        cmd_ready_next = (state_next == ST_IDLE);
        rsp_valid_next = (state_next == ST_RESP);

        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    wb_we_next   = I_cmd_we;
                    wb_adr_next  = I_cmd_adr;
                    wb_dat_next  = I_cmd_dat;
                    wb_cyc_next  = 1'b1;
                    wb_stb_next  = 1'b1;
                    tmo_cnt_next = '0;
                end
            end
            ST_BUS: begin
                // ACK takes priority over a timeout reached in the same cycle.
                if (ack_seen) begin
                    rsp_dat_next = O_wb_we ? 8'h00 : I_wb_dat;
                    rsp_err_next = 1'b0;
                    wb_cyc_next  = 1'b0;
                    wb_stb_next  = 1'b0;
                end else if (tmo_hit) begin
                    rsp_dat_next = 8'h00;
                    rsp_err_next = 1'b1;
                    wb_cyc_next  = 1'b0;
                    wb_stb_next  = 1'b0;
                end else if (tmo_cnt != '1) begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
